// File: rtl/serial2parallel_if.sv
// Parallel-side handshake of the serial-to-parallel receiver: head-of-FIFO word,
// its valid flag and the consumer's ready.
`ifndef DATAPATH_WIDTH
`define DATAPATH_WIDTH 8
`endif

interface serial2parallel_if #(
    parameter int DATA_WIDTH = `DATAPATH_WIDTH
);
    logic [DATA_WIDTH-1:0] par_data;
    logic                  par_valid;
    logic                  par_ready;

    modport master (
        output par_data,
        output par_valid,
        input  par_ready
    );

    modport slave (
        input  par_data,
        input  par_valid,
        output par_ready
    );
endinterface

// File: rtl/serial2parallel.sv
// Recovers MSB-first words from a serial line using an external align pulse,
// buffering completed words in a 2-entry FIFO with a valid/ready handshake.
`ifndef DATAPATH_WIDTH
`define DATAPATH_WIDTH 8
`endif

module serial2parallel #(
    parameter  int DATA_WIDTH = `DATAPATH_WIDTH,
    localparam int CNT_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                    serial_clk,
    input  logic                    rstn,
    input  logic                    serial_data,
    input  logic                    rx_en,
    input  logic                    align,
    input  logic                    clr_err,
    serial2parallel_if.master       par,
    output logic                    overrun,
    output logic                    align_err,
    output logic                    busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  align_err_q, align_err_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] restart;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  push;
    logic                  aerr_set;
    logic                  pop;
    logic                  full;
    logic                  do_push;
    logic                  ovr_set;

    assign shifted = {shreg_q[DATA_WIDTH-2:0], serial_data};
    assign restart = {{(DATA_WIDTH-1){1'b0}}, serial_data};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        push_word = shifted;
        aerr_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_en && align) begin
                    shreg_d = restart;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!rx_en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (align) begin
                    // An align on a word boundary (counter wrapped) is a normal restart.
                    aerr_set = (cnt_q != '0);
                    shreg_d  = restart;
                    cnt_d    = CNT_ONE;
                end else begin
                    shreg_d = shifted;
                    if (cnt_q == CNT_LAST) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = (count_q != 2'd0) && par.par_ready;
        full     = (count_q == 2'd2);
        // When full, a simultaneous pop frees the slot that wr_ptr points at.
        do_push  = push && (!full || pop);
        ovr_set  = push && full && !pop;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_word;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (do_push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && pop) begin
            count_d = count_q - 2'd1;
        end
        overrun_d   = (overrun_q   && !clr_err) || ovr_set;
        align_err_d = (align_err_q && !clr_err) || aerr_set;
    end

    always_ff @(posedge serial_clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            overrun_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            align_err_q <= align_err_d;
        end
    end

    assign par.par_data  = mem_q[rd_ptr_q];
    assign par.par_valid = (count_q != 2'd0);
    assign overrun       = overrun_q;
    assign align_err     = align_err_q;
    assign busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel at DATA_WIDTH=8: vector table for the
// basic words plus hand-written sequences for overrun, alignment and reset cases.
`timescale 1ns/1ps

module tb_serial2parallel;

    logic serial_clk = 1'b0;
    logic rstn;
    logic serial_data;
    logic rx_en;
    logic align;
    logic clr_err;
    logic overrun;
    logic align_err;
    logic busy;

    int pass_cnt = 0;
    int total    = 0;

    serial2parallel_if #(.DATA_WIDTH(8)) bus ();

    serial2parallel #(.DATA_WIDTH(8)) dut (
        .serial_clk  (serial_clk),
        .rstn        (rstn),
        .serial_data (serial_data),
        .rx_en       (rx_en),
        .align       (align),
        .clr_err     (clr_err),
        .par         (bus.master),
        .overrun     (overrun),
        .align_err   (align_err),
        .busy        (busy)
    );

    always #5 serial_clk = ~serial_clk;

    typedef struct {
        logic       rx_en;
        logic       align;
        logic       sd;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       eo;
        logic       ea;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rx, input logic al, input logic sd,
                                input logic rdy, input logic clr, input logic ev,
                                input logic [7:0] ed, input logic eo,
                                input logic ea, input logic eb);
        vec_t v;
        v.rx_en = rx; v.align = al; v.sd = sd; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ea = ea; v.eb = eb;
        tbl.push_back(v);
    endfunction

    task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                           input logic eo, input logic ea, input logic eb);
        chk1({tag, ".par_valid"}, 32'(bus.par_valid), 32'(ev));
        if (ev) chk1({tag, ".par_data"}, 32'(bus.par_data), 32'(ed));
        chk1({tag, ".overrun"}, 32'(overrun), 32'(eo));
        chk1({tag, ".align_err"}, 32'(align_err), 32'(ea));
        chk1({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic drive(input logic rx, input logic al, input logic sd,
                         input logic rdy, input logic clr);
        rx_en = rx; align = al; serial_data = sd; bus.par_ready = rdy; clr_err = clr;
        @(posedge serial_clk);
        #1;
    endtask

    // Sends bits n-1..0 of w, MSB first, with align on the first bit if requested.
    task automatic stream(input logic [7:0] w, input int n, input logic al_first,
                          input logic rdy);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, al_first && (i == n - 1), w[i], rdy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;
        rstn = 1'b0; rx_en = 1'b0; align = 1'b0; serial_data = 1'b0;
        clr_err = 1'b0; bus.par_ready = 1'b0;

        // Single 0xA5 word, then rx_en drop pops it and idles the FSM.
        w = 8'hA5;
        for (int i = 7; i >= 0; i--)
            add(1'b1, i == 7, w[i], 1'b1, 1'b0, i == 0, 8'hA5, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Back-to-back 0x3C, 0xC3 after a single align.
        w = 8'h3C;
        for (int i = 7; i >= 0; i--)
            add(1'b1, i == 7, w[i], 1'b1, 1'b0, i == 0, 8'h3C, 1'b0, 1'b0, 1'b1);
        w = 8'hC3;
        for (int i = 7; i >= 0; i--)
            add(1'b1, 1'b0, w[i], 1'b1, 1'b0, i == 0, 8'hC3, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        @(posedge serial_clk); #1;
        @(posedge serial_clk); #1;
        chk1("rst.par_data", 32'(bus.par_data), 32'h0);
        chk_all("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].rx_en, tbl[k].align, tbl[k].sd, tbl[k].rdy, tbl[k].clr);
            chk_all($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ed, tbl[k].eo,
                    tbl[k].ea, tbl[k].eb);
        end

        // Overrun: consumer stalled across three words.
        stream(8'h11, 8, 1'b1, 1'b0);
        chk_all("ovr_w1", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        stream(8'h22, 8, 1'b0, 1'b0);
        chk_all("ovr_w2", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        stream(8'h33, 8, 1'b0, 1'b0);
        chk_all("ovr_w3", 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("ovr_pop1", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("ovr_pop2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Mid-word align after 3 bits, then a clean 0x5A.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("mid_part", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("mid_align", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        stream(8'h5A, 7, 1'b0, 1'b1);
        chk_all("mid_word", 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("mid_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("mid_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // rx_en dropped after 4 bits; align while disabled is ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i == 1, 1'b1, 1'b1, 1'b0);
            chk_all($sformatf("dis%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        stream(8'hF0, 8, 1'b1, 1'b1);
        chk_all("en_word", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("en_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset mid-word with one FIFO entry and align_err set.
        stream(8'h77, 8, 1'b1, 1'b0);
        chk_all("rst_fill", 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        stream(8'h05, 3, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("rst_aerr", 1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        rstn = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk1("rst2.par_data", 32'(bus.par_data), 32'h0);
        chk_all("rst2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'(i & 1), 1'b1, 1'b0);
        end
        chk_all("rst_noalign", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        stream(8'h96, 8, 1'b1, 1'b1);
        chk_all("rst_recover", 1'b1, 8'h96, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
